memaccess_stage: RTL and testbench

- Stage 4 (MEM) of the DLX five-stage pipeline. Consumes the EX stage outputs: ALU result/address, store data, instruction and store-enable.
- Performs byte/half/word loads and stores against a handshaked data memory, then registers the results for write-back.
- Stalls the upstream stages while a memory access is outstanding, and aborts accesses that time out.

---
 rtl/memaccess_stage.sv | 151 +++++++++++++++
 tb/tb_memaccess_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/memaccess_stage.sv
// DLX MEM stage: byte/half/word loads and stores over a req/ack data memory,
// with upstream stall while waiting and abort after TIMEOUT unanswered cycles.
module memaccess_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock4,
  input  logic        reset4,
  input  logic [31:0] alu_in4,
  input  logic [31:0] bin4,
  input  logic [31:0] inst_in4,
  input  logic        mem_wr_en_in,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        dmem_we,
  output logic        dmem_req,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] alu_out4,
  output logic [31:0] lmd_out4,
  output logic [31:0] inst_out4,
  output logic        stall4,
  output logic        misalign_err,
  output logic        mem_fault
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [5:0] OP_LB  = 6'b000001;
  localparam logic [5:0] OP_LBU = 6'b000010;
  localparam logic [5:0] OP_LH  = 6'b000011;
  localparam logic [5:0] OP_LHU = 6'b000100;
  localparam logic [5:0] OP_LW  = 6'b000101;
  localparam logic [5:0] OP_SB  = 6'b001000;
  localparam logic [5:0] OP_SH  = 6'b001001;
  localparam logic [5:0] OP_SW  = 6'b001010;

  logic [0:0]    state;
  logic [CW-1:0] cnt;

  logic [5:0]  opcode;
  logic [1:0]  k;
  logic        is_load, is_store, is_byte, is_half, is_word;
  logic        aligned, access, memop, misal, abort, complete;
  logic [31:0] rdata_shift, load_ext;
  logic [15:0] half_sel;

  assign opcode = inst_in4[31:26];
  assign k      = alu_in4[1:0];

  always_comb begin
    is_load  = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_LH) ||
               (opcode == OP_LHU) || (opcode == OP_LW);
    is_store = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
    is_byte  = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
    is_half  = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
    is_word  = (opcode == OP_LW) || (opcode == OP_SW);
  end

  assign aligned = is_byte || (is_half && !alu_in4[0]) || (is_word && (k == 2'b00));
  assign access  = is_load || (is_store && mem_wr_en_in);
  assign memop   = access && aligned;
  assign misal   = access && !aligned;

  // An ack in the would-be abort cycle wins, so abort requires ~dmem_ack.
  assign abort    = (state == WAIT) && memop && !dmem_ack && (cnt == CW'(TIMEOUT));
  assign complete = memop && dmem_ack;

  assign dmem_req  = memop && !abort && reset4;
  assign stall4    = memop && !dmem_ack && !abort && reset4;
  assign dmem_we   = dmem_req && is_store;
  assign dmem_addr = {alu_in4[31:2], 2'b00};

  always_comb begin
    dmem_be = 4'b0000;
    if (dmem_req) begin
      if (is_load || is_word) dmem_be = 4'b1111;
      else if (is_byte)       dmem_be = 4'b0001 << k;
      else                    dmem_be = alu_in4[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    if (is_byte)      dmem_wdata = {4{bin4[7:0]}};
    else if (is_half) dmem_wdata = {2{bin4[15:0]}};
    else              dmem_wdata = bin4;
  end

  assign rdata_shift = dmem_rdata >> {k, 3'b000};
  assign half_sel    = alu_in4[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (opcode)
      OP_LB:   load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      OP_LBU:  load_ext = {24'h000000, rdata_shift[7:0]};
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      OP_LW:   load_ext = dmem_rdata;
      default: load_ext = 32'h0;
    endcase
  end

  always_ff @(posedge clock4) begin
    if (!reset4) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop && !dmem_ack) begin
            state <= WAIT;
            cnt   <= CW'(1);
          end
        end
        default: begin
          if (!memop || dmem_ack || abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock4) begin
    if (!reset4) begin
      alu_out4     <= 32'h0;
      lmd_out4     <= 32'h0;
      inst_out4    <= 32'h0;
      mem_fault    <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      mem_fault    <= abort;
      misalign_err <= misal;
      if (stall4) begin
        inst_out4 <= 32'h0;
      end else begin
        inst_out4 <= inst_in4;
        alu_out4  <= alu_in4;
      end
      if (complete && is_load) lmd_out4 <= load_ext;
      else if (abort || misal) lmd_out4 <= 32'h0;
    end
  end

endmodule

// File: tb/tb_memaccess_stage.sv
// Self-checking bench for memaccess_stage: vector table for single-cycle ops,
// hand sequences for stall, timeout and reset-in-WAIT, scoreboard on registers.
module tb_memaccess_stage;

  localparam int TO = 4;

  logic        clock4 = 1'b0;
  logic        reset4;
  logic [31:0] alu_in4, bin4, inst_in4, dmem_rdata;
  logic        mem_wr_en_in, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, alu_out4, lmd_out4, inst_out4;
  logic [3:0]  dmem_be;
  logic        dmem_we, dmem_req, stall4, misalign_err, mem_fault;

  memaccess_stage #(.TIMEOUT(TO)) dut (
    .clock4(clock4), .reset4(reset4), .alu_in4(alu_in4), .bin4(bin4),
    .inst_in4(inst_in4), .mem_wr_en_in(mem_wr_en_in), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_we(dmem_we),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_out4(alu_out4), .lmd_out4(lmd_out4), .inst_out4(inst_out4),
    .stall4(stall4), .misalign_err(misalign_err), .mem_fault(mem_fault)
  );

  always #5 clock4 = ~clock4;

  localparam logic [5:0] LB = 6'b000001, LBU = 6'b000010, LH = 6'b000011,
                         LHU = 6'b000100, LW = 6'b000101, SB = 6'b001000,
                         SH = 6'b001001, SW = 6'b001010, ADD = 6'b000000;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] alu, bin, rdata;
    logic        wren, ack;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] wdata, lmd;
    logic        me;
  } vec_t;

  typedef struct {
    logic [31:0] alu, lmd, inst;
    logic        mf, me;
  } exp_t;

  vec_t  vecs[13];
  exp_t  sb[$];
  int    n_chk = 0, n_err = 0;
  int    seq = 1;
  logic [31:0] m_alu = 0, m_lmd = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] bin,
                       input logic wren, input logic ack, input logic [31:0] rdata);
    inst_in4     = {op, 10'h0, 16'(seq)};
    seq++;
    alu_in4      = alu;
    bin4         = bin;
    mem_wr_en_in = wren;
    dmem_ack     = ack;
    dmem_rdata   = rdata;
  endtask

  task automatic push(input logic [31:0] alu, input logic [31:0] lmd, input logic [31:0] inst,
                      input logic mf, input logic me);
    exp_t e;
    e.alu = alu; e.lmd = lmd; e.inst = inst; e.mf = mf; e.me = me;
    sb.push_back(e);
    m_alu = alu;
    m_lmd = lmd;
  endtask

  task automatic push_stall();
    push(m_alu, m_lmd, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic tick(input string nm);
    exp_t e;
    @(posedge clock4);
    #1;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({nm, "_alu_out"}, alu_out4, e.alu);
      chk({nm, "_lmd_out"}, lmd_out4, e.lmd);
      chk({nm, "_inst_out"}, inst_out4, e.inst);
      chk({nm, "_mem_fault"}, {31'h0, mem_fault}, {31'h0, e.mf});
      chk({nm, "_misalign"}, {31'h0, misalign_err}, {31'h0, e.me});
    end
  endtask

  task automatic chk_rs(input string nm, input logic req, input logic stall);
    #1;
    chk({nm, "_req"}, {31'h0, dmem_req}, {31'h0, req});
    chk({nm, "_stall"}, {31'h0, stall4}, {31'h0, stall});
  endtask

  initial begin
    //            op   alu        bin        rdata      wr ack req we be       wdata        lmd         me
    vecs[0]  = '{LW,  32'h100, 32'h0,      32'hDEADBEEF, 0, 1, 1, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0};
    vecs[1]  = '{SH,  32'h202, 32'hABCD,   32'h0,        1, 1, 1, 1, 4'b1100, 32'hABCDABCD, 32'hDEADBEEF, 0};
    vecs[2]  = '{SH,  32'h202, 32'hABCD,   32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'hDEADBEEF, 0};
    vecs[3]  = '{LW,  32'h101, 32'h0,      32'h11111111, 0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        1};
    vecs[4]  = '{SB,  32'h001, 32'h5A,     32'h0,        1, 1, 1, 1, 4'b0010, 32'h5A5A5A5A, 32'h0,        0};
    vecs[5]  = '{SW,  32'h008, 32'h12345678, 32'h0,      1, 1, 1, 1, 4'b1111, 32'h12345678, 32'h0,        0};
    vecs[6]  = '{LH,  32'h006, 32'h0,      32'h80017FFF, 0, 1, 1, 0, 4'b1111, 32'h0,        32'hFFFF8001, 0};
    vecs[7]  = '{LHU, 32'h006, 32'h0,      32'h80017FFF, 0, 1, 1, 0, 4'b1111, 32'h0,        32'h00008001, 0};
    vecs[8]  = '{LB,  32'h102, 32'h0,      32'h80112233, 0, 1, 1, 0, 4'b1111, 32'h0,        32'h00000011, 0};
    vecs[9]  = '{ADD, 32'h777, 32'h0,      32'h0,        1, 0, 0, 0, 4'b0000, 32'h0,        32'h00000011, 0};
    vecs[10] = '{LH,  32'h003, 32'h0,      32'hFFFFFFFF, 0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        1};
    vecs[11] = '{SW,  32'h002, 32'h9,      32'h0,        1, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        1};
    vecs[12] = '{SB,  32'h003, 32'h9,      32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        0};

    reset4 = 1'b0;
    drive(ADD, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    inst_in4 = 32'h0;
    repeat (2) @(posedge clock4);
    #1;
    chk("rst_alu_out", alu_out4, 32'h0);
    chk("rst_lmd_out", lmd_out4, 32'h0);
    chk("rst_inst_out", inst_out4, 32'h0);
    chk("rst_flags", {30'h0, mem_fault, misalign_err}, 32'h0);
    reset4 = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].alu, vecs[i].bin, vecs[i].wren, vecs[i].ack, vecs[i].rdata);
      chk_rs($sformatf("v%0d", i), vecs[i].req, 1'b0);
      chk($sformatf("v%0d_we", i), {31'h0, dmem_we}, {31'h0, vecs[i].we});
      chk($sformatf("v%0d_be", i), {28'h0, dmem_be}, {28'h0, vecs[i].be});
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), dmem_addr, {vecs[i].alu[31:2], 2'b00});
      if (vecs[i].we)  chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wdata);
      push(vecs[i].alu, vecs[i].lmd, inst_in4, 1'b0, vecs[i].me);
      tick($sformatf("v%0d", i));
    end

    // Byte loads from 0x103 with three wait cycles, signed then unsigned.
    for (int u = 0; u < 2; u++) begin
      drive(u == 0 ? LB : LBU, 32'h103, 32'h0, 1'b0, 1'b0, 32'h80112233);
      for (int c = 0; c < 3; c++) begin
        chk_rs($sformatf("lb%0d_w%0d", u, c), 1'b1, 1'b1);
        push_stall();
        tick($sformatf("lb%0d_w%0d", u, c));
      end
      dmem_ack = 1'b1;
      chk_rs($sformatf("lb%0d_ack", u), 1'b1, 1'b0);
      push(32'h103, u == 0 ? 32'hFFFFFF80 : 32'h00000080, inst_in4, 1'b0, 1'b0);
      tick($sformatf("lb%0d_done", u));
    end

    // Timeout: v=0 never acks, v=1 acks in the would-be abort cycle.
    for (int v = 0; v < 2; v++) begin
      drive(LW, 32'h40, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D);
      for (int c = 0; c < TO; c++) begin
        chk_rs($sformatf("to%0d_c%0d", v, c), 1'b1, 1'b1);
        push_stall();
        tick($sformatf("to%0d_c%0d", v, c));
      end
      dmem_ack = (v == 1);
      chk_rs($sformatf("to%0d_c%0d", v, TO), v == 1, 1'b0);
      push(32'h40, v == 0 ? 32'h0 : 32'hCAFEF00D, inst_in4, v == 0, 1'b0);
      tick($sformatf("to%0d_end", v));
      drive(ADD, 32'h55, 32'h0, 1'b0, 1'b0, 32'h0);
      push(32'h55, m_lmd, inst_in4, 1'b0, 1'b0);
      tick($sformatf("to%0d_after", v));
    end

    // Reset asserted in WAIT cycle 2.
    drive(LW, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0BADF00D);
    for (int c = 0; c < 2; c++) begin
      chk_rs($sformatf("rw_c%0d", c), 1'b1, 1'b1);
      push_stall();
      tick($sformatf("rw_c%0d", c));
    end
    reset4 = 1'b0;
    chk_rs("rw_inrst", 1'b0, 1'b0);
    push(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick("rw_rst");
    reset4 = 1'b1;
    // Counter must restart from zero: full TIMEOUT of waiting before abort.
    drive(LW, 32'h84, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < TO; c++) begin
      chk_rs($sformatf("rw_to_c%0d", c), 1'b1, 1'b1);
      push_stall();
      tick($sformatf("rw_to_c%0d", c));
    end
    chk_rs("rw_to_abort", 1'b0, 1'b0);
    push(32'h84, 32'h0, inst_in4, 1'b1, 1'b0);
    tick("rw_to_end");
    drive(LW, 32'h88, 32'h0, 1'b0, 1'b1, 32'h600DCAFE);
    chk_rs("rw_fresh", 1'b1, 1'b0);
    push(32'h88, 32'h600DCAFE, inst_in4, 1'b0, 1'b0);
    tick("rw_fresh");

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
